// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the IF and MEM pipeline stages share one single-ported memory.
// Only one requester is granted at a time; DM wins ties unless IF has been starved
// for STARVE_MAX consecutive DM grants. Every output except pipe_stall is registered.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          pipe_stall
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q,      state_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          mem_req_q,    mem_req_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DW-1:0] if_rdata_q,   if_rdata_d;
    logic [DW-1:0] dm_rdata_q,   dm_rdata_d;
    logic          if_ack_q,     if_ack_d;
    logic          dm_ack_q,     dm_ack_d;
    logic          grant_dm;

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
        end
    end

    // Grant selection, memory sequencing and ack generation.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        grant_dm     = dm_req && !(if_req && (starve_cnt_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req && (starve_cnt_q < STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_req) begin
                    state_d      = BUSY_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ack_d   = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    dm_ack_d  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign if_ack     = if_ack_q;
    assign dm_ack     = dm_ack_q;
    assign pipe_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: variable-latency memory model,
// per-port ack scoreboards, memory-request scoreboard and ordered ack log.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_ack, dm_req, dm_we, dm_ack;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ready, pipe_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pipe_stall(pipe_stall)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    endtask

    // Memory model: answers after mem_wait extra cycles; rdata is junk when not ready.
    logic [31:0] mem_arr [logic [31:0]];
    int          mem_wait = 0;
    int          wcnt     = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            mem_rdata = '0;
        end else if (mem_req && !mem_ready) begin
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1;
                wcnt      = 0;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else        mem_rdata = mem_rd(mem_addr);
            end else begin
                wcnt++;
                mem_rdata = $urandom;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Scoreboards.
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];
    string       ack_log = "";
    logic [31:0] dm_last = '0;

    // Monitor: memory-side requests, field stability, acks and stall.
    bit          prev_req = 0, prev_if_ack = 0, prev_dm_ack = 0;
    logic [31:0] held_addr, held_wdata;
    int          req_len = 0, last_req_len = 0;
    mreq_t       cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req    = 0;
            prev_if_ack = 0;
            prev_dm_ack = 0;
            req_len     = 0;
        end else begin
            chk("pipe_stall", pipe_stall, (if_req & ~if_ack) | (dm_req & ~dm_ack));
            chk("ack_exclusive", if_ack & dm_ack, 0);
            chk("if_ack_pulse", if_ack & prev_if_ack, 0);
            chk("dm_ack_pulse", dm_ack & prev_dm_ack, 0);
            if (mem_req && !prev_req) begin
                chk("mem_q_nonempty", mem_q.size() > 0, 1);
                if (mem_q.size() > 0) begin
                    cur = mem_q.pop_front();
                    chk("mem_we", mem_we, cur.we);
                    chk("mem_addr", mem_addr, cur.addr);
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
                held_addr  = mem_addr;
                held_wdata = mem_wdata;
                req_len    = 0;
            end
            if (mem_req && prev_req)
                chk("mem_hold", {mem_addr, mem_wdata}, {held_addr, held_wdata});
            if (mem_req) req_len++;
            if (!mem_req && prev_req) last_req_len = req_len;
            if (if_ack) begin
                ack_log = {ack_log, "I"};
                chk("if_q_nonempty", if_q.size() > 0, 1);
                if (if_q.size() > 0) chk("if_rdata", if_rdata, if_q.pop_front());
            end
            if (dm_ack) begin
                ack_log = {ack_log, "D"};
                chk("dm_q_nonempty", dm_q.size() > 0, 1);
                if (dm_q.size() > 0) chk("dm_rdata", dm_rdata, dm_q.pop_front());
            end
            prev_req    = mem_req;
            prev_if_ack = if_ack;
            prev_dm_ack = dm_ack;
        end
    end

    // Requester drivers. hold=1 keeps req high to re-issue back to back.
    task automatic do_if(input logic [31:0] a, input bit hold, output int lat);
        @(posedge clk); #1;
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(mem_rd(a));
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (if_ack) break;
        end
        chk("if_ack_seen", if_ack, 1);
        if (!hold) begin
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic do_dm(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input bit hold, output int lat);
        logic [31:0] v;
        @(posedge clk); #1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        if (we) v = dm_last;
        else begin
            v       = mem_rd(a);
            dm_last = v;
        end
        dm_q.push_back(v);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (dm_ack) break;
        end
        chk("dm_ack_seen", dm_ack, 1);
        if (!hold) begin
            @(posedge clk); #1;
            dm_req = 1'b0;
        end
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_cyc;
        int          exp_lat;   // negedges from req drive to ack
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, k;
        mreq_t m;

        vecs[0] = '{0, 0, 32'h10, 32'h0,        0, 3};
        vecs[1] = '{1, 1, 32'h40, 32'hDEADBEEF, 3, 6};
        vecs[2] = '{1, 0, 32'h40, 32'h0,        0, 3};
        vecs[3] = '{0, 0, 32'h14, 32'h0,        2, 5};
        vecs[4] = '{1, 0, 32'h80, 32'h0,        1, 4};
        vecs[5] = '{1, 1, 32'h80, 32'h12345678, 0, 3};
        vecs[6] = '{0, 0, 32'h80, 32'h0,        0, 3};

        mem_arr[32'h10] = 32'h8C220004;
        rst_n = 1'b0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        chk("rst_stall", pipe_stall, 0);
        #2 rst_n = 1'b1;

        // Single-requester vectors: latency, request length, data.
        foreach (vecs[i]) begin
            mem_wait = vecs[i].wait_cyc;
            m = '{vecs[i].we, vecs[i].addr, vecs[i].wdata};
            mem_q.push_back(m);
            if (vecs[i].is_dm) do_dm(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, lat);
            else               do_if(vecs[i].addr, 0, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_req_len", i), last_req_len, vecs[i].wait_cyc + 1);
        end

        // Simultaneous requests: DM first, then IF.
        mem_wait = 1;
        ack_log  = "";
        mem_q.push_back('{1, 32'h44, 32'hCAFEF00D});
        mem_q.push_back('{0, 32'h24, 32'h0});
        fork
            begin int l; do_if(32'h24, 0, l); end
            begin int l; do_dm(1, 32'h44, 32'hCAFEF00D, 0, l); end
        join
        chk_str("tie_order", ack_log, "DI");

        // Starvation: IF held, DM re-issued back to back, two rounds.
        mem_wait = 0;
        ack_log  = "";
        k = 0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < SMAX; j++) begin
                mem_q.push_back('{1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k)});
                k++;
            end
            mem_q.push_back('{0, 32'h200 + 32'(4 * r), 32'h0});
        end
        mem_q.push_back('{1, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k)});
        fork
            begin
                int l;
                do_if(32'h200, 1, l);
                do_if(32'h204, 0, l);
            end
            begin
                int l;
                for (int n = 0; n < 2 * SMAX + 1; n++)
                    do_dm(1, 32'h100 + 32'(4 * n), 32'h1000 + 32'(n), n != 2 * SMAX, l);
            end
        join
        chk_str("starve_order", ack_log, "DDDDIDDDDID");

        // Reset in the middle of a DM access.
        mem_wait = 10;
        mem_q.push_back('{0, 32'h300, 32'h0});
        @(posedge clk); #1;
        dm_we = 0; dm_addr = 32'h300; dm_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) break;
        end
        chk("pre_reset_mem_req", mem_req, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_acks", {if_ack, dm_ack}, 0);
        chk("midrst_fields", {mem_we, mem_addr}, 0);
        chk("midrst_dm_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        dm_q.delete();
        if_q.delete();
        dm_last = '0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        mem_wait = 0;
        mem_q.push_back('{0, 32'h10, 32'h0});
        do_if(32'h10, 0, lat);
        chk("post_reset_latency", lat, 3);

        repeat (3) @(negedge clk);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("acks_drained", if_q.size() + dm_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
